stage_if_bp: RTL and testbench

STAGE_IF_BP -- requirements
Module: stage_if_bp

---
 rtl/bp_pkg.sv | 31 +++
 rtl/btb_array.sv | 79 +++++++
 rtl/stage_if_bp.sv | 79 +++++++
 tb/tb_stage_if_bp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating direction counter and its step function.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bp_pkg;

    // 2-bit saturating counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // A freshly allocated entry predicts taken, but one not-taken outcome flips it.
    localparam ctr_t CTR_ALLOC = WT;
    // Reset value. It never predicts, because the entry's valid bit is clear anyway.
    localparam ctr_t CTR_RESET = WNT;

    // Saturating step toward the resolved direction.
    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        logic [1:0] v;
        v = c;
        if (taken) begin
            if (v != 2'b11) v = v + 2'b01;
        end else begin
            if (v != 2'b00) v = v - 2'b01;
        end
        return ctr_t'(v);
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB: a combinational lookup on the fetch PC and a registered update from resolved branches.
// Latency: lookup 0 cycles; an update becomes visible on the cycle after its strobe. A lookup never sees a same-cycle update.
// Backpressure: none. An update is taken every cycle that upd_vld is high.
// Ports: i_clk/i_reset, lookup_pc -> hit_taken/hit_target, upd_vld/upd_pc/upd_target/upd_taken.
module btb_array
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] lookup_pc,
    output logic        hit_taken,
    output logic [31:0] hit_target,
    input  logic        upd_vld,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [BTB_ENTRIES-1:0] valid_q;
    ctr_t                   ctr_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [31:0]            tgt_q [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    ctr_t             lk_ctr;

    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Word-aligned fetch: the byte-offset bits take no part in index or tag.
    logic unused_lsbs;
    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx     = lookup_pc[IDX+1:2];
    assign lk_tag     = lookup_pc[31:IDX+2];
    assign lk_ctr     = ctr_q[lk_idx];
    assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign hit_taken  = lk_hit && lk_ctr[1];
    assign hit_target = tgt_q[lk_idx];

    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[31:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Control state: valid bits and counters. An async reset also drops any same-cycle update.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (upd_vld) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd_taken);
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= CTR_ALLOC;
            end
        end
    end

    // Data state has no reset; the valid bits gate every hit. On a hit the tag
    // rewrite is a no-op. On a miss it is the allocation.
    always_ff @(posedge i_clk) begin
        if (upd_vld && upd_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/stage_if_bp.sv
// Fetch stage: PC register and next-PC select (redirect > BTB prediction > PC+4), with a BTB-backed predictor.
// Latency: o_imem_addr is the combinational next PC; IMEM data returns one cycle later alongside o_pc.
// Backpressure: i_stall holds the PC, but a redirect always advances it so that no redirect is lost.
// Ports: i_clk/i_reset, i_stall, i_redirect_*, i_bp_* (update), o_imem_addr/i_imem_rdata, o_pc/o_instr/o_pred_*.
module stage_if_bp
    import bp_pkg::*;
#(
    parameter int          BTB_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_bp_update,
    input  logic [31:0] i_bp_pc,
    input  logic [31:0] i_bp_target,
    input  logic        i_bp_taken,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target
);

    // r_pc starts one word early, so the first prefetch address is RESET_PC itself.
    localparam logic [31:0] PC_RST = RESET_PC - 32'd4;

    logic [31:0] r_pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        btb_taken;
    logic [31:0] btb_target;

    btb_array #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .lookup_pc  (r_pc),
        .hit_taken  (btb_taken),
        .hit_target (btb_target),
        .upd_vld    (i_bp_update),
        .upd_pc     (i_bp_pc),
        .upd_target (i_bp_target),
        .upd_taken  (i_bp_taken)
    );

    assign pc_plus4 = r_pc + 32'd4;

    // While reset is held, the prefetch address is pinned to RESET_PC so that a stray redirect cannot leak out.
    always_comb begin
        pc_next = pc_plus4;
        if (i_reset) begin
            pc_next = RESET_PC;
        end else if (i_redirect_valid) begin
            pc_next = i_redirect_pc;
        end else if (btb_taken) begin
            pc_next = btb_target;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= PC_RST;
        end else if (!i_stall || i_redirect_valid) begin
            r_pc <= pc_next;
        end
    end

    assign o_imem_addr   = pc_next;
    assign o_pc          = r_pc;
    assign o_instr       = i_imem_rdata;
    assign o_pred_taken  = btb_taken;
    assign o_pred_target = btb_taken ? btb_target : pc_plus4;

endmodule

// File: tb/tb_stage_if_bp.sv
module tb_stage_if_bp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir_vld = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        upd = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_tgt = '0;
    logic        upd_tk = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_tk;
    logic [31:0] pred_tgt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Synchronous IMEM model: one-cycle latency, the data is a known function of the address.
    always @(posedge clk) imem_rdata <= imem_addr ^ 32'hA5A5_0000;

    stage_if_bp #(
        .BTB_ENTRIES (64),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_stall          (stall),
        .i_redirect_valid (redir_vld),
        .i_redirect_pc    (redir_pc),
        .i_bp_update      (upd),
        .i_bp_pc          (upd_pc),
        .i_bp_target      (upd_tgt),
        .i_bp_taken       (upd_tk),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .o_pc             (pc),
        .o_instr          (instr),
        .o_pred_taken     (pred_tk),
        .o_pred_target    (pred_tgt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redir_vld = 1'b1;
        redir_pc  = a;
        cyc();
        redir_vld = 1'b0;
        #1;
    endtask

    task automatic bp_upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
        upd     = 1'b1;
        upd_pc  = a;
        upd_tgt = t;
        upd_tk  = tk;
        cyc();
        upd = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk("rst_pc", pc, 32'hFFFF_FFFC);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pred", {31'b0, pred_tk}, 32'h0);
        rst = 1'b0;
        #1;
        chk("seq_addr0", imem_addr, 32'h0);
        cyc();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_pc0", pc, 32'h0);
        cyc();
        chk("seq_addr8", imem_addr, 32'h8);
        cyc();
        chk("seq_addr12", imem_addr, 32'hC);
        chk("seq_pred", {31'b0, pred_tk}, 32'h0);
        chk("instr_pass", instr, 32'h8 ^ 32'hA5A5_0000);

        // Allocate on a taken miss
        bp_upd(32'h10, 32'h40, 1'b1);
        redirect_to(32'h10);
        chk("alloc_pc", pc, 32'h10);
        chk("alloc_pred", {31'b0, pred_tk}, 32'h1);
        chk("alloc_tgt", pred_tgt, 32'h40);
        chk("alloc_addr", imem_addr, 32'h40);
        cyc();
        chk("follow_pc", pc, 32'h40);
        chk("follow_addr", imem_addr, 32'h44);

        // Two not-taken updates: 10 -> 01 -> 00
        bp_upd(32'h10, 32'h0, 1'b0);
        bp_upd(32'h10, 32'h0, 1'b0);
        redirect_to(32'h10);
        chk("nt_pred", {31'b0, pred_tk}, 32'h0);
        chk("nt_addr", imem_addr, 32'h14);
        chk("nt_tgt", pred_tgt, 32'h14);

        // Aliasing: 0x110 has the same index as 0x10 and replaces it
        bp_upd(32'h110, 32'h300, 1'b1);
        redirect_to(32'h10);
        chk("alias_old_pred", {31'b0, pred_tk}, 32'h0);
        chk("alias_old_addr", imem_addr, 32'h14);
        redirect_to(32'h110);
        chk("alias_new_pred", {31'b0, pred_tk}, 32'h1);
        chk("alias_new_addr", imem_addr, 32'h300);

        // Saturation at 11: the counter goes 10 -> 11 -> 11, then a not-taken step to 10 still predicts taken
        bp_upd(32'h110, 32'h300, 1'b1);
        bp_upd(32'h110, 32'h300, 1'b1);
        bp_upd(32'h110, 32'hDEAD_0000, 1'b0);
        redirect_to(32'h110);
        chk("sat_pred", {31'b0, pred_tk}, 32'h1);
        chk("sat_tgt_kept", pred_tgt, 32'h300);

        // A same-cycle lookup and update see the old contents; the stall holds the PC
        stall   = 1'b1;
        upd     = 1'b1;
        upd_pc  = 32'h110;
        upd_tgt = 32'h0;
        upd_tk  = 1'b0;
        #1;
        chk("nobypass_pred", {31'b0, pred_tk}, 32'h1);
        cyc();
        upd = 1'b0;
        #1;
        chk("stall_pc1", pc, 32'h110);
        chk("post_upd_pred", {31'b0, pred_tk}, 32'h0);
        chk("post_upd_tgt", pred_tgt, 32'h114);
        cyc();
        chk("stall_pc2", pc, 32'h110);
        cyc();
        chk("stall_pc3", pc, 32'h110);

        // A redirect overrides the stall
        redirect_to(32'h200);
        chk("stall_redir_pc", pc, 32'h200);
        stall = 1'b0;

        // A taken hit rewrites the target (counter 01 -> 10)
        bp_upd(32'h110, 32'h500, 1'b1);
        redirect_to(32'h110);
        chk("hit_tgt_pred", {31'b0, pred_tk}, 32'h1);
        chk("hit_tgt", pred_tgt, 32'h500);

        // A not-taken miss allocates nothing
        bp_upd(32'h24, 32'h80, 1'b0);
        redirect_to(32'h24);
        chk("ntmiss_pred", {31'b0, pred_tk}, 32'h0);
        chk("ntmiss_addr", imem_addr, 32'h28);

        // Reset mid-stream, with an update and a redirect in the same cycle
        rst       = 1'b1;
        upd       = 1'b1;
        upd_pc    = 32'h24;
        upd_tgt   = 32'h80;
        upd_tk    = 1'b1;
        redir_vld = 1'b1;
        redir_pc  = 32'h300;
        #1;
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_pc", pc, 32'hFFFF_FFFC);
        chk("mid_rst_pred", {31'b0, pred_tk}, 32'h0);
        cyc();
        rst       = 1'b0;
        upd       = 1'b0;
        redir_vld = 1'b0;
        #1;
        chk("post_rst_pc", pc, 32'hFFFF_FFFC);
        chk("post_rst_addr", imem_addr, 32'h0);
        redirect_to(32'h110);
        chk("cleared_110", {31'b0, pred_tk}, 32'h0);
        redirect_to(32'h24);
        chk("cleared_24", {31'b0, pred_tk}, 32'h0);
        chk("cleared_24_addr", imem_addr, 32'h28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
